pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It sits beside the decode-stage control unit and generates all pipeline write-enable, hold and flush strobes. It covers load-use stalls, branch and jump redirects, and a multi-cycle data-memory handshake with timeout. It also keeps a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for dmem_ack before flagging error (>=2)
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
id_opcode  input  6  opcode of instruction in IF/ID
id_rs  input  5  rs field in IF/ID
id_rt  input  5  rt field in IF/ID
ex_memread  input  1  MemRead of instruction in ID/EX
ex_rt  input  5  load destination register in ID/EX
ex_branch_taken  input  1  Branch AND zero, resolved in EX
mem_req  input  1  EX/MEM instruction accesses data memory (MemRead|MemWrite)
dmem_ack  input  1  data memory completes access this cycle
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  IF/ID synchronous clear
idex_bubble  output  1  zero ID/EX control fields
exmem_hold  output  1  hold EX/MEM and MEM/WB
pc_sel  output  2  00 PC+4, 01 branch target, 10 jump target
mem_timeout_err  output  1  sticky timeout flag
stall_cnt  output  CNT_W  saturating count of stall/wait cycles

Behaviour:
- Clock is clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=RUN, stall_cnt=0, mem_timeout_err=0, wait counter=0.
  - Combinational outputs take their RUN/no-hazard values: pc_write=1, ifid_write=1, other strobes 0, pc_sel=00.
  - Reset mid-wait abandons the access.
- States: RUN, MEM_WAIT, ERR.
- Hazard terms:
  - load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (ex_rt==id_rt & id_opcode uses rt as source)).
  - rt counts as a source for R-type (000000–000011), sw (101011) and beq (000100). It does not for lw, xori or j.
- RUN:
  - If mem_req & !dmem_ack, go to MEM_WAIT and load the wait counter with 1.
  - In that same cycle, freeze the pipeline: pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0, no flush.
  - If mem_req & dmem_ack, proceed normally (single-cycle access).
- MEM_WAIT:
  - Freeze as above. Branch, jump and load-use are ignored while frozen.
  - On dmem_ack, return to RUN; the next cycle advances.
  - If the wait counter reaches MEM_TIMEOUT without ack, go to ERR and set mem_timeout_err.
- ERR:
  - Permanent freeze (pc_write=0, ifid_write=0, exmem_hold=1) until reset.
  - mem_timeout_err stays 1.
- Priority in RUN with no memory freeze (highest first):
  1. ex_branch_taken: pc_sel=01, ifid_flush=1, idex_bubble=1, pc_write=1. Overrides load_use and jump.
  2. id_opcode==100000 (j): pc_sel=10, ifid_flush=1, pc_write=1, idex_bubble=0.
  3. load_use: pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. The load advances, so load_use clears the next cycle.
  4. Otherwise normal advance.
- stall_cnt increments each cycle where pc_write=0 and it is not yet saturated. It holds at all-ones. Flush-only cycles do not count.
- Latency: all hazard outputs are combinational from inputs and state, with zero-cycle response. Only state, wait counter and stall_cnt are registered.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants: OP_ADD 000000, OP_SUB 000001, OP_OR 000010, OP_AND 000011, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_XORI 001111, OP_J 100000.
  - PC_SEL enum {PC_SEQ, PC_BR, PC_JMP}.
  - State enum {RUN, MEM_WAIT, ERR}.
- One natural sub-module, hazard_sat_counter (parameterised width, enable, saturating). It is used for stall_cnt and the wait counter.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_opcode=000000, id_rs=5 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0→1. Repeat with ex_rt=0 → no stall.
- Branch over load-use: ex_branch_taken=1 with load_use true → pc_sel=01, ifid_flush=1, idex_bubble=1, pc_write=1; stall_cnt unchanged.
- Jump: id_opcode=100000, no other hazards → pc_sel=10, ifid_flush=1, idex_bubble=0. xori with rt==ex_rt and ex_memread=1 → no stall.
- Memory wait: mem_req=1, dmem_ack low for 3 cycles, then high → freeze strobes for exactly 4 cycles, then RUN; stall_cnt=4.
- Timeout: MEM_TIMEOUT=4, dmem_ack never asserted → ERR with mem_timeout_err=1 after 4 wait cycles; outputs frozen. Assert rst_n=0 mid-ERR → immediate return to reset values.
- Saturation: CNT_W=2, hold load-use for 5 separate stalls → stall_cnt sticks at 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, PC-select and sequencer-state encodings for the 5-stage pipeline.
package cpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_XORI = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b100000;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pcSel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } ctrlState_e;

  // True when the opcode reads rt as a source operand (a load can feed it through rt).
  function automatic logic usesRtSrc(input logic [5:0] op);
    logic res;
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SW, OP_BEQ: res = 1'b1;
      OP_LW, OP_XORI, OP_J:                         res = 1'b0;
      default:                                      res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and enable together load the value 1.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] countReg;
  logic [W-1:0] baseVal;
  logic [W-1:0] countNext;

  always_comb begin
    baseVal   = clr ? '0 : countReg;
    countNext = baseVal;
    if (en && !(&baseVal)) begin
      countNext = baseVal + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countReg <= '0;
    end else begin
      countReg <= countNext;
    end
  end

  assign count = countReg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/jump redirects, data-memory wait with timeout,
// and a saturating stall-cycle counter. All strobes are combinational from inputs and state.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       pc_sel,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrlState_e        stateReg;
  ctrlState_e        stateNext;
  logic              errReg;
  logic              errNext;
  logic              loadUse;
  logic              memStall;
  logic              freeze;
  logic              waitClr;
  logic              waitEn;
  logic [WAIT_W-1:0] waitCnt;
  pcSel_e            pcSel;

  assign loadUse  = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && usesRtSrc(id_opcode)));
  assign memStall = mem_req && !dmem_ack;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    pcSel       = PC_SEQ;
    freeze      = 1'b0;
    stateNext   = stateReg;
    errNext     = errReg;
    waitClr     = 1'b0;
    waitEn      = 1'b0;

    case (stateReg)
      RUN: begin
        waitClr = 1'b1;
        if (memStall) begin
          // Clear plus enable loads the wait counter with 1 for this first waiting cycle.
          freeze    = 1'b1;
          waitEn    = 1'b1;
          stateNext = MEM_WAIT;
        end else if (ex_branch_taken) begin
          pcSel       = PC_BR;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_opcode == OP_J) begin
          pcSel      = PC_JMP;
          ifid_flush = 1'b1;
        end else if (loadUse) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        freeze = 1'b1;
        if (dmem_ack) begin
          stateNext = RUN;
        end else begin
          waitEn = 1'b1;
          if (waitCnt >= WAIT_LAST) begin
            stateNext = ERR;
            errNext   = 1'b1;
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        stateNext = RUN;
      end
    endcase

    // A memory freeze overrides every redirect and stall decided above.
    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b1;
      pcSel       = PC_SEQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= RUN;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      errReg   <= errNext;
    end
  end

  hazard_sat_counter #(
    .W(WAIT_W)
  ) waitCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (waitClr),
    .en    (waitEn),
    .count (waitCnt)
  );

  hazard_sat_counter #(
    .W(CNT_W)
  ) stallCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (!pc_write),
    .count (stall_cnt)
  );

  assign pc_sel          = pcSel;
  assign mem_timeout_err = errReg;

endmodule
